alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID->EXE issue stage that produces the control and operand bundle consumed by the RV32I ALU (exe_alu_opc_r, exe_sel_pc_r, exe_pc_r, exe_reg1_r, exe_src2_r).
- Decodes OP, OP-IMM, LUI and AUIPC instructions and builds the immediate or register second operand.
- Holds the result in a single-entry EXE pipeline register with a valid/ready handshake on both sides, plus flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID offers an instruction.
- id_ready  output  1  stage can accept this cycle.
- id_instr  input  32  raw instruction.
- id_pc  input  32  instruction PC.
- id_reg1  input  32  rs1 value.
- id_reg2  input  32  rs2 value.
- flush  input  1  discard held and incoming instruction.
- exe_ready  input  1  EXE consumes the held bundle.
- exe_valid_r  output  1  bundle valid.
- exe_alu_opc_r  output  4  ALU opcode.
- exe_sel_pc_r  output  1  1 = ALU uses PC as the first operand.
- exe_pc_r  output  32  registered PC.
- exe_reg1_r  output  32  first operand; forced to 0 for LUI.
- exe_src2_r  output  32  second operand (rs2 or immediate).
- exe_rd_r  output  5  destination register.
- exe_rd_we_r  output  1  writeback enable.
- exe_illegal_r  output  1  undecodable instruction.

Behaviour:
- Reset: all outputs 0 asynchronously; bundle empty; id_ready becomes 1 after reset deassertion.
- id_ready = !exe_valid_r || exe_ready (combinational). No skid buffer.
- Accept = id_valid && id_ready. Latency is 1 cycle: the bundle appears on the clock edge after accept.
- exe_valid_r next-state:
  - flush: 0 (highest priority).
  - else if id_ready: id_valid.
  - else: hold.
- Payload registers load only on accept && !flush. Otherwise they hold, including while stalled.
- ALU opcode encodings: AND=0111, OR=0110, XOR=0100, ADD=0000, SUB=1000, SLT=0010, SLTU=0011, SLL=0001, SRL=0101, SRA=1101.
- OP (0110011): opc = {funct7[5], funct3}; src2 = id_reg2.
  - Legal funct7 values: 0000000, or 0100000 only with funct3 000 or 101.
- OP-IMM (0010011): src2 = sign-extended I-immediate (instr[31:20]).
  - opc = {0, funct3}, except funct3 101 with funct7 0100000 gives SRA.
  - SLLI requires funct7 = 0000000; SRLI/SRAI require funct7 0000000 or 0100000.
  - The full immediate is passed unchanged; the ALU uses src2[4:0] for shifts.
- LUI (0110111): opc ADD, sel_pc 0, reg1 forced 0, src2 = {instr[31:12], 12'b0}.
- AUIPC (0010111): opc ADD, sel_pc 1, src2 = U-immediate.
- All decoded instructions: rd = instr[11:7], rd_we = 1. rd = 0 still asserts rd_we; the register file ignores x0 writes.
- Any other opcode or illegal funct7: illegal = 1, rd_we = 0, opc ADD, src2 0, sel_pc 0. The bundle is still issued valid for exception handling.
- Flush while the bundle is held: valid drops on the next edge; payload is don't-care.
- Flush with a simultaneous accept: the incoming instruction is dropped.
- Reset mid-stall: the bundle is cleared immediately; nothing is retained.

Decomposition:
- Package alu_pkg holds:
  - the ten ALU opcode localparams;
  - RV32I major opcodes OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC;
  - funct7 constants F7_BASE = 0000000 and F7_ALT = 0100000.
- Sub-module alu_ctrl_decoder: purely combinational; maps instr/reg1/reg2 to {opc, sel_pc, reg1_sel, src2, rd, rd_we, illegal}.
- The top level holds only the pipeline register and the handshake logic.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), reg1=5, reg2=7, exe_ready=1 -> next cycle valid=1, opc 0000, reg1 5, src2 7, rd 3, rd_we 1, sel_pc 0.
- SUB 0x402081B3 -> opc 1000. ADDI x1,x0,-1 (0xFFF00093) -> src2 0xFFFFFFFF, opc 0000. SRAI x5,x6,3 (0x40335293) -> opc 1101, src2 0x00000403.
- AUIPC x2,0x12345 (0x12345117), pc 0x100 -> sel_pc 1, src2 0x12345000, exe_pc 0x100. LUI 0x12345137 with reg1=0xDEAD -> reg1 0, sel_pc 0.
- Backpressure: exe_ready=0 for 3 cycles while held -> id_ready=0 and payload frozen. Raise exe_ready with a new id_valid -> same-cycle accept; new bundle appears next edge with no bubble.
- Illegal instruction 0x0000000B -> illegal 1, rd_we 0, valid 1. SLLI with funct7 0100000 (0x40009093) -> illegal 1.
- Flush while full with id_valid=1 -> exe_valid_r=0 next edge. Assert rst_n=0 mid-stall -> all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the RV32I ALU issue path: ALU opcode encodings,
// major opcodes, funct7 values and the registered EXE bundle layout.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b1000;
    localparam logic [3:0] ALU_SLL  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OR   = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [3:0]  opc;
        logic        sel_pc;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } exe_bundle_t;

    // alt selects the SUB/SRA variant; it only matters for funct3 000 and 101.
    function automatic logic [3:0] alu_opc(input logic [2:0] funct3, input logic alt);
        logic [3:0] opc;
        case (funct3)
            3'b000:  opc = alt ? ALU_SUB : ALU_ADD;
            3'b001:  opc = ALU_SLL;
            3'b010:  opc = ALU_SLT;
            3'b011:  opc = ALU_SLTU;
            3'b100:  opc = ALU_XOR;
            3'b101:  opc = alt ? ALU_SRA : ALU_SRL;
            3'b110:  opc = ALU_OR;
            default: opc = ALU_AND;
        endcase
        return opc;
    endfunction

endpackage

// File: rtl/alu_ctrl_decoder.sv
// Combinational decode of OP, OP-IMM, LUI and AUIPC into ALU control and operands.
// Anything else is flagged illegal and given a harmless ADD with a zero second operand.
module alu_ctrl_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    output logic [3:0]  opc,
    output logic        sel_pc,
    output logic [31:0] reg1_sel,
    output logic [31:0] src2,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;
    logic        legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        opc      = ALU_ADD;
        sel_pc   = 1'b0;
        reg1_sel = reg1;
        src2     = '0;
        rd       = instr[11:7];
        legal    = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal = (funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101));
                opc   = alu_opc(funct3, funct7 == F7_ALT);
                src2  = reg2;
            end
            OPC_OP_IMM: begin
                // Shift immediates keep their upper bits; the ALU only looks at src2[4:0].
                opc  = alu_opc(funct3, (funct3 == 3'b101) && (funct7 == F7_ALT));
                src2 = imm_i;
                case (funct3)
                    3'b001:  legal = (funct7 == F7_BASE);
                    3'b101:  legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: legal = 1'b1;
                endcase
            end
            OPC_LUI: begin
                legal    = 1'b1;
                reg1_sel = '0;
                src2     = imm_u;
            end
            OPC_AUIPC: begin
                legal  = 1'b1;
                sel_pc = 1'b1;
                src2   = imm_u;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            opc    = ALU_ADD;
            sel_pc = 1'b0;
            src2   = '0;
        end
        rd_we   = legal;
        illegal = !legal;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EXE issue stage: decodes one instruction and holds the ALU bundle in a
// single-entry pipeline register with flush.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [31:0]     id_instr,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_reg1,
    input  logic [XLEN-1:0] id_reg2,
    input  logic            flush,
    input  logic            exe_ready,
    output logic            exe_valid_r,
    output logic [3:0]      exe_alu_opc_r,
    output logic            exe_sel_pc_r,
    output logic [XLEN-1:0] exe_pc_r,
    output logic [XLEN-1:0] exe_reg1_r,
    output logic [XLEN-1:0] exe_src2_r,
    output logic [4:0]      exe_rd_r,
    output logic            exe_rd_we_r,
    output logic            exe_illegal_r
);

    // Handshake: a transfer happens on a rising edge where valid && ready. id_ready
    // is high when the register is empty or EXE drains it in the same cycle, so a
    // stalled bundle never moves and a draining one is replaced without a bubble.
    logic        exe_valid_d, exe_valid_q;
    exe_bundle_t bundle_d, bundle_q;
    exe_bundle_t dec_bundle;
    logic        accept;

    alu_ctrl_decoder u_decoder (
        .instr    (id_instr),
        .reg1     (id_reg1),
        .reg2     (id_reg2),
        .opc      (dec_bundle.opc),
        .sel_pc   (dec_bundle.sel_pc),
        .reg1_sel (dec_bundle.reg1),
        .src2     (dec_bundle.src2),
        .rd       (dec_bundle.rd),
        .rd_we    (dec_bundle.rd_we),
        .illegal  (dec_bundle.illegal)
    );
    assign dec_bundle.pc = id_pc;

    assign id_ready = !exe_valid_q || exe_ready;
    assign accept   = id_valid && id_ready;

    always_comb begin
        exe_valid_d = exe_valid_q;
        if (flush) begin
            exe_valid_d = 1'b0;
        end else if (id_ready) begin
            exe_valid_d = id_valid;
        end
        bundle_d = bundle_q;
        if (accept && !flush) begin
            bundle_d = dec_bundle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exe_valid_q <= 1'b0;
            bundle_q    <= '0;
        end else begin
            exe_valid_q <= exe_valid_d;
            bundle_q    <= bundle_d;
        end
    end

    assign exe_valid_r   = exe_valid_q;
    assign exe_alu_opc_r = bundle_q.opc;
    assign exe_sel_pc_r  = bundle_q.sel_pc;
    assign exe_pc_r      = bundle_q.pc;
    assign exe_reg1_r    = bundle_q.reg1;
    assign exe_src2_r    = bundle_q.src2;
    assign exe_rd_r      = bundle_q.rd;
    assign exe_rd_we_r   = bundle_q.rd_we;
    assign exe_illegal_r = bundle_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed literal cases, then random traffic checked
// every cycle against a queue-based model of the issue register.
module tb_alu_issue_stage;

    typedef struct packed {
        logic [3:0]  opc;
        logic        sel_pc;
        logic [31:0] pc;
        logic [31:0] reg1;
        logic [31:0] src2;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } bundle_t;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        id_valid = 1'b0;
    logic        id_ready;
    logic [31:0] id_instr = '0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_reg1 = '0;
    logic [31:0] id_reg2 = '0;
    logic        flush = 1'b0;
    logic        exe_ready = 1'b0;
    logic        exe_valid_r;
    logic [3:0]  exe_alu_opc_r;
    logic        exe_sel_pc_r;
    logic [31:0] exe_pc_r;
    logic [31:0] exe_reg1_r;
    logic [31:0] exe_src2_r;
    logic [4:0]  exe_rd_r;
    logic        exe_rd_we_r;
    logic        exe_illegal_r;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_reg1       (id_reg1),
        .id_reg2       (id_reg2),
        .flush         (flush),
        .exe_ready     (exe_ready),
        .exe_valid_r   (exe_valid_r),
        .exe_alu_opc_r (exe_alu_opc_r),
        .exe_sel_pc_r  (exe_sel_pc_r),
        .exe_pc_r      (exe_pc_r),
        .exe_reg1_r    (exe_reg1_r),
        .exe_src2_r    (exe_src2_r),
        .exe_rd_r      (exe_rd_r),
        .exe_rd_we_r   (exe_rd_we_r),
        .exe_illegal_r (exe_illegal_r)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bundle_t model(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
        bundle_t b;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        b = '0;
        b.pc = pc;
        b.reg1 = r1;
        b.rd = ins[11:7];
        ok = 1'b0;
        if (op == 7'h33) begin
            ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
            b.opc = {f7[5], f3};
            b.src2 = r2;
        end else if (op == 7'h13) begin
            b.src2 = {{20{ins[31]}}, ins[31:20]};
            b.opc = {1'b0, f3};
            ok = 1'b1;
            if (f3 == 3'd1) ok = (f7 == 7'h00);
            if (f3 == 3'd5) begin
                ok = (f7 == 7'h00) || (f7 == 7'h20);
                if (f7 == 7'h20) b.opc = 4'b1101;
            end
        end else if (op == 7'h37) begin
            ok = 1'b1;
            b.reg1 = 32'd0;
            b.src2 = {ins[31:12], 12'd0};
        end else if (op == 7'h17) begin
            ok = 1'b1;
            b.sel_pc = 1'b1;
            b.src2 = {ins[31:12], 12'd0};
        end
        if (ok) begin
            b.rd_we = 1'b1;
        end else begin
            b.opc = 4'b0000;
            b.sel_pc = 1'b0;
            b.src2 = 32'd0;
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    // Scoreboard: the held bundle (at most one) the DUT must be presenting.
    bundle_t exp_q[$];
    logic    m_ready;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            m_ready = (exp_q.size() == 0) || exe_ready;
            if (flush) begin
                exp_q.delete();
            end else if (m_ready) begin
                if (exp_q.size() != 0) void'(exp_q.pop_front());
                if (id_valid) exp_q.push_back(model(id_instr, id_pc, id_reg1, id_reg2));
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("cmp_id_ready", {31'd0, id_ready}, {31'd0, (exp_q.size() == 0) || exe_ready});
            chk("cmp_valid", {31'd0, exe_valid_r}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                chk("cmp_opc", {28'd0, exe_alu_opc_r}, {28'd0, exp_q[0].opc});
                chk("cmp_sel_pc", {31'd0, exe_sel_pc_r}, {31'd0, exp_q[0].sel_pc});
                chk("cmp_pc", exe_pc_r, exp_q[0].pc);
                chk("cmp_reg1", exe_reg1_r, exp_q[0].reg1);
                chk("cmp_src2", exe_src2_r, exp_q[0].src2);
                chk("cmp_rd", {27'd0, exe_rd_r}, {27'd0, exp_q[0].rd});
                chk("cmp_rd_we", {31'd0, exe_rd_we_r}, {31'd0, exp_q[0].rd_we});
                chk("cmp_illegal", {31'd0, exe_illegal_r}, {31'd0, exp_q[0].illegal});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        int n;
        #1;
        id_instr = ins;
        id_pc    = pc;
        id_reg1  = r1;
        id_reg2  = r2;
        id_valid = 1'b1;
        n = 0;
        while (!id_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("send_wait_ready", {31'd0, id_ready}, 32'd1);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 5: w[6:0] = 7'h33;
            1:    w[6:0] = 7'h13;
            2:    w[6:0] = 7'h37;
            3:    w[6:0] = 7'h17;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        #3 rst_n = 1'b0;
        #20;
        chk("rst_valid", {31'd0, exe_valid_r}, 32'd0);
        chk("rst_opc", {28'd0, exe_alu_opc_r}, 32'd0);
        chk("rst_src2", exe_src2_r, 32'd0);
        chk("rst_pc", exe_pc_r, 32'd0);
        chk("rst_rd_we", {31'd0, exe_rd_we_r}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        started = 1'b1;
        exe_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, id_ready}, 32'd1);

        send(32'h002081B3, 32'h40, 32'd5, 32'd7);
        chk("add_valid", {31'd0, exe_valid_r}, 32'd1);
        chk("add_opc", {28'd0, exe_alu_opc_r}, 32'h0);
        chk("add_reg1", exe_reg1_r, 32'd5);
        chk("add_src2", exe_src2_r, 32'd7);
        chk("add_rd", {27'd0, exe_rd_r}, 32'd3);
        chk("add_rd_we", {31'd0, exe_rd_we_r}, 32'd1);
        chk("add_sel_pc", {31'd0, exe_sel_pc_r}, 32'd0);

        send(32'h402081B3, 32'h44, 32'd5, 32'd7);
        chk("sub_opc", {28'd0, exe_alu_opc_r}, 32'h8);

        send(32'hFFF00093, 32'h48, 32'd0, 32'd0);
        chk("addi_src2", exe_src2_r, 32'hFFFF_FFFF);
        chk("addi_opc", {28'd0, exe_alu_opc_r}, 32'h0);

        send(32'h40335293, 32'h4C, 32'h80, 32'd0);
        chk("srai_opc", {28'd0, exe_alu_opc_r}, 32'hD);
        chk("srai_src2", exe_src2_r, 32'h0000_0403);

        send(32'h12345117, 32'h100, 32'd9, 32'd0);
        chk("auipc_sel_pc", {31'd0, exe_sel_pc_r}, 32'd1);
        chk("auipc_src2", exe_src2_r, 32'h1234_5000);
        chk("auipc_pc", exe_pc_r, 32'h100);

        send(32'h12345137, 32'h104, 32'hDEAD, 32'd0);
        chk("lui_reg1", exe_reg1_r, 32'd0);
        chk("lui_sel_pc", {31'd0, exe_sel_pc_r}, 32'd0);
        chk("lui_src2", exe_src2_r, 32'h1234_5000);

        send(32'h0000000B, 32'h108, 32'd1, 32'd2);
        chk("ill_illegal", {31'd0, exe_illegal_r}, 32'd1);
        chk("ill_rd_we", {31'd0, exe_rd_we_r}, 32'd0);
        chk("ill_valid", {31'd0, exe_valid_r}, 32'd1);
        chk("ill_src2", exe_src2_r, 32'd0);

        send(32'h40009093, 32'h10C, 32'd1, 32'd2);
        chk("slli_alt_illegal", {31'd0, exe_illegal_r}, 32'd1);

        // Backpressure: hold an ADD for three cycles while a SUB waits.
        send(32'h002081B3, 32'h200, 32'd5, 32'd7);
        #1;
        exe_ready = 1'b0;
        id_valid  = 1'b1;
        id_instr  = 32'h402081B3;
        id_pc     = 32'h204;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_id_ready", {31'd0, id_ready}, 32'd0);
            chk("bp_opc_frozen", {28'd0, exe_alu_opc_r}, 32'h0);
            chk("bp_pc_frozen", exe_pc_r, 32'h200);
        end
        #1;
        exe_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, id_ready}, 32'd1);
        @(posedge clk);
        #1;
        id_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", {31'd0, exe_valid_r}, 32'd1);
        chk("bp_next_opc", {28'd0, exe_alu_opc_r}, 32'h8);
        chk("bp_next_pc", exe_pc_r, 32'h204);

        // Flush while full with a simultaneous offer.
        send(32'h002081B3, 32'h300, 32'd5, 32'd7);
        #1;
        exe_ready = 1'b0;
        id_valid  = 1'b1;
        id_instr  = 32'h12345137;
        flush     = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        id_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", {31'd0, exe_valid_r}, 32'd0);

        // Asynchronous reset in the middle of a stall.
        exe_ready = 1'b1;
        send(32'h402081B3, 32'h400, 32'd5, 32'd7);
        #1;
        exe_ready = 1'b0;
        @(posedge clk);
        #2;
        chk("stall_valid", {31'd0, exe_valid_r}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, exe_valid_r}, 32'd0);
        chk("arst_opc", {28'd0, exe_alu_opc_r}, 32'd0);
        chk("arst_pc", exe_pc_r, 32'd0);
        chk("arst_src2", exe_src2_r, 32'd0);
        chk("arst_reg1", exe_reg1_r, 32'd0);
        chk("arst_rd", {27'd0, exe_rd_r}, 32'd0);
        chk("arst_rd_we", {31'd0, exe_rd_we_r}, 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int c = 0; c < 2500; c++) begin
            @(posedge clk);
            #1;
            id_valid  = ($urandom_range(0, 3) != 0);
            exe_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 15) == 0);
            id_instr  = rand_instr();
            id_pc     = $urandom;
            id_reg1   = $urandom;
            id_reg2   = $urandom;
        end
        @(posedge clk);
        #1;
        id_valid  = 1'b0;
        flush     = 1'b0;
        exe_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
